// File: rtl/sent_tx_pulse_gen.sv
// SENT transmitter pulse generator.
// Every period has a fixed low portion followed by a high portion, which
// together make up the period length in ticks. The period is a sync (56
// ticks), a pause (PAUSE_TICKS) or a data nibble (12 + value ticks).
module sent_tx_pulse_gen #(
  parameter int CLK_PER_TICK = 3,
  parameter int LOW_TICKS    = 5,
  parameter int PAUSE_TICKS  = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sync,
  input  logic       pause,
  input  logic       pulse,
  input  logic [3:0] data_nibble,
  output logic       sent_out,
  output logic       pulse_done,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH
  } state_t;

  typedef enum logic [1:0] {
    PT_NIBBLE,
    PT_SYNC,
    PT_PAUSE
  } period_t;

  localparam logic [7:0] PRESC_LAST    = 8'(CLK_PER_TICK - 1);
  localparam logic [7:0] PRESC_PRE     = 8'(CLK_PER_TICK - 2);
  localparam logic [9:0] LOW_LAST_TICK = 10'(LOW_TICKS - 1);
  localparam logic [9:0] SYNC_LEN      = 10'd56;
  localparam logic [9:0] PAUSE_LEN     = 10'(PAUSE_TICKS);
  localparam logic [9:0] NIBBLE_BASE   = 10'd12;

  state_t      state;
  period_t     period_type;
  logic [3:0]  nibble;
  logic [7:0]  presc;
  logic [9:0]  tick_cnt;

  logic        request;
  logic        tick_done;
  logic [9:0]  period_len;
  logic [9:0]  last_tick;
  logic        low_end;
  logic        high_end;
  logic        high_pre_end;

  // Period length from the latched type and nibble, and the end-of-phase
  // conditions derived from the prescaler and tick counter.
  always_comb begin
    request    = sync | pause | pulse;
    tick_done  = (presc == PRESC_LAST);
    case (period_type)
      PT_SYNC:  period_len = SYNC_LEN;
      PT_PAUSE: period_len = PAUSE_LEN;
      default:  period_len = NIBBLE_BASE + {6'd0, nibble};
    endcase
    last_tick    = period_len - 10'd1;
    low_end      = (state == LOW) && tick_done && (tick_cnt == LOW_LAST_TICK);
    high_end     = (state == HIGH) && tick_done && (tick_cnt == last_tick);
    high_pre_end = (state == HIGH) && (presc == PRESC_PRE) && (tick_cnt == last_tick);
  end

  // Period sequencer: counters, latched period description and registered
  // line outputs. pulse_done is raised one cycle ahead so it lines up with
  // the final high cycle, and the restart decision is taken at its edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      period_type <= PT_NIBBLE;
      nibble      <= 4'd0;
      presc       <= 8'd0;
      tick_cnt    <= 10'd0;
      sent_out    <= 1'b1;
      pulse_done  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pulse_done <= 1'b0;
          presc      <= 8'd0;
          tick_cnt   <= 10'd0;
          if (request) begin
            state    <= LOW;
            sent_out <= 1'b0;
            busy     <= 1'b1;
          end
        end

        LOW: begin
          pulse_done <= 1'b0;
          if (tick_done) begin
            presc    <= 8'd0;
            tick_cnt <= tick_cnt + 10'd1;
          end else begin
            presc <= presc + 8'd1;
          end
          if (low_end) begin
            state    <= HIGH;
            sent_out <= 1'b1;
            if (sync) begin
              period_type <= PT_SYNC;
              nibble      <= 4'd0;
            end else if (pause) begin
              period_type <= PT_PAUSE;
              nibble      <= 4'd0;
            end else if (pulse) begin
              period_type <= PT_NIBBLE;
              nibble      <= data_nibble;
            end else begin
              period_type <= PT_NIBBLE;
              nibble      <= 4'd0;
            end
          end
        end

        HIGH: begin
          if (high_end) begin
            pulse_done <= 1'b0;
            presc      <= 8'd0;
            tick_cnt   <= 10'd0;
            if (request) begin
              state    <= LOW;
              sent_out <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            pulse_done <= high_pre_end;
            if (tick_done) begin
              presc    <= 8'd0;
              tick_cnt <= tick_cnt + 10'd1;
            end else begin
              presc <= presc + 8'd1;
            end
          end
        end

        default: begin
          state      <= IDLE;
          sent_out   <= 1'b1;
          pulse_done <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sent_tx_pulse_gen.sv
// Self-checking bench for sent_tx_pulse_gen with CLK_PER_TICK=2,
// LOW_TICKS=5, PAUSE_TICKS=20. A cycle-position reference model predicts
// the line, busy and pulse_done every cycle; directed scenarios add
// period-length and back-to-back checks; a random soak finishes the run.
module tb_sent_tx_pulse_gen;

  localparam int CPT     = 2;
  localparam int LOWT    = 5;
  localparam int PAUSET  = 20;
  localparam int LOW_CYC = LOWT * CPT;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sync = 1'b0;
  logic       pause = 1'b0;
  logic       pulse = 1'b0;
  logic [3:0] data_nibble = 4'd0;
  logic       sent_out;
  logic       pulse_done;
  logic       busy;

  int checks = 0;
  int errors = 0;

  int pos  = -1;
  int plen = 0;

  int dut_cnt     = 0;
  int last_period = 0;
  int done_cnt    = 0;
  bit measuring   = 1'b0;
  int meas_busy   = 0;
  int meas_idle   = 0;

  sent_tx_pulse_gen #(
    .CLK_PER_TICK(CPT),
    .LOW_TICKS   (LOWT),
    .PAUSE_TICKS (PAUSET)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sync       (sync),
    .pause      (pause),
    .pulse      (pulse),
    .data_nibble(data_nibble),
    .sent_out   (sent_out),
    .pulse_done (pulse_done),
    .busy       (busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  function automatic int len_ticks(bit s, bit p, bit q, logic [3:0] n);
    if (s) return 56;
    if (p) return PAUSET;
    if (q) return 12 + int'(n);
    return 12;
  endfunction

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic es, eb, ed;
    if (pos < 0) begin
      es = 1'b1; eb = 1'b0; ed = 1'b0;
    end else begin
      es = (pos >= LOW_CYC);
      eb = 1'b1;
      ed = (pos == plen - 1);
    end
    checks++;
    assert (sent_out === es) else begin
      errors++;
      $error("[TB] FAIL sent_out pos=%0d observed=%b expected=%b", pos, sent_out, es);
    end
    checks++;
    assert (busy === eb) else begin
      errors++;
      $error("[TB] FAIL busy pos=%0d observed=%b expected=%b", pos, busy, eb);
    end
    checks++;
    assert (pulse_done === ed) else begin
      errors++;
      $error("[TB] FAIL pulse_done pos=%0d observed=%b expected=%b", pos, pulse_done, ed);
    end
  endtask

  task automatic applyStimulus(input int n);
    bit s, p, q, rq;
    logic [3:0] nb;
    for (int i = 0; i < n; i++) begin
      s  = (sync === 1'b1);
      p  = (pause === 1'b1);
      q  = (pulse === 1'b1);
      nb = data_nibble;
      rq = s | p | q;
      @(posedge clk);
      if (reset !== 1'b1) begin
        pos = -1;
      end else if (pos < 0) begin
        if (rq) begin
          pos  = 0;
          plen = 0;
        end
      end else begin
        if (pos == LOW_CYC - 1) plen = len_ticks(s, p, q, nb) * CPT;
        if (pos == plen - 1) pos = rq ? 0 : -1;
        else pos++;
      end
      #1;
      checkOutput();
      if (busy === 1'b1) dut_cnt++;
      if (pulse_done === 1'b1) begin
        last_period = dut_cnt;
        dut_cnt     = 0;
        done_cnt++;
      end
      if (measuring) begin
        if (busy === 1'b1) meas_busy++;
        else meas_idle++;
      end
    end
  endtask

  task automatic wait_done(input string tag, input int exp_cycles, input int maxc);
    bit got;
    got = 1'b0;
    for (int n = 0; n < maxc && !got; n++) begin
      applyStimulus(1);
      if (pulse_done === 1'b1) got = 1'b1;
    end
    check_val({tag, "_done_seen"}, int'(got), 1);
    check_val(tag, last_period, exp_cycles);
  endtask

  task automatic wait_idle(input int maxc);
    bit got;
    got = 1'b0;
    for (int n = 0; n < maxc && !got; n++) begin
      applyStimulus(1);
      if (busy === 1'b0) got = 1'b1;
    end
    check_val("idle_reached", int'(got), 1);
  endtask

  initial begin
    int exp_sum;
    int dones_before;
    logic [3:0] nb;

    $display("[TB] start");

    reset = 1'b0;
    applyStimulus(3);
    reset = 1'b1;
    applyStimulus(2);

    sync = 1'b1;
    wait_done("sync_first", 112, 200);
    wait_done("sync_second", 112, 200);
    sync = 1'b0;
    wait_idle(5);

    pulse = 1'b1;
    data_nibble = 4'd0;
    wait_done("nibble0", 24, 100);
    data_nibble = 4'd15;
    applyStimulus(12);
    pulse = 1'b0;
    wait_done("nibble15", 54, 100);
    wait_idle(5);

    pulse = 1'b1;
    data_nibble = 4'd7;
    applyStimulus(11);
    data_nibble = 4'd3;
    pulse = 1'b0;
    wait_done("nibble7_latched", 38, 100);
    wait_idle(5);
    check_val("idle_line_high", int'(sent_out), 1);

    pulse = 1'b1;
    data_nibble = 4'd9;
    applyStimulus(4);
    pulse = 1'b0;
    wait_done("no_request_at_latch", 24, 100);
    wait_idle(5);

    sync = 1'b1;
    pause = 1'b1;
    pulse = 1'b1;
    applyStimulus(11);
    sync = 1'b0;
    pulse = 1'b0;
    wait_done("priority_sync", 112, 200);
    applyStimulus(11);
    pause = 1'b0;
    wait_done("pause_len", 40, 100);
    wait_idle(5);

    dones_before = done_cnt;
    sync = 1'b1;
    applyStimulus(30);
    reset = 1'b0;
    #1;
    pos = -1;
    dut_cnt = 0;
    check_val("reset_line_high", int'(sent_out), 1);
    check_val("reset_not_busy", int'(busy), 0);
    check_val("reset_no_done", int'(pulse_done), 0);
    sync = 1'b0;
    pulse = 1'b1;
    data_nibble = 4'd5;
    applyStimulus(2);
    reset = 1'b1;
    check_val("abort_no_done", done_cnt, dones_before);
    wait_done("after_reset_nibble", 34, 100);
    pulse = 1'b0;
    wait_idle(5);

    exp_sum = 56;
    meas_busy = 0;
    meas_idle = 0;
    dones_before = done_cnt;
    measuring = 1'b1;
    sync = 1'b1;
    wait_done("b2b_sync", 112, 200);
    sync = 1'b0;
    pulse = 1'b1;
    for (int k = 0; k < 8; k++) begin
      nb = 4'($urandom_range(0, 15));
      data_nibble = nb;
      exp_sum += 12 + int'(nb);
      wait_done("b2b_nibble", (12 + int'(nb)) * CPT, 100);
    end
    pulse = 1'b0;
    pause = 1'b1;
    exp_sum += PAUSET;
    wait_done("b2b_pause", PAUSET * CPT, 100);
    measuring = 1'b0;
    pause = 1'b0;
    check_val("b2b_total_cycles", meas_busy, exp_sum * CPT);
    check_val("b2b_idle_gaps", meas_idle, 0);
    check_val("b2b_period_count", done_cnt - dones_before, 10);
    wait_idle(5);

    for (int i = 0; i < 600; i++) begin
      sync  = ($urandom_range(0, 15) == 0);
      pause = ($urandom_range(0, 7) == 0);
      pulse = ($urandom_range(0, 1) == 1);
      data_nibble = 4'($urandom_range(0, 15));
      applyStimulus(1);
    end
    sync = 1'b0;
    pause = 1'b0;
    pulse = 1'b0;
    wait_idle(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
